// File: rtl/maint_ctrl_multi.sv
// maint_ctrl_multi: N-channel maintenance-cycle controller.
// Each channel runs its own IDLE/MAINT/ERROR machine. A maintenance window
// opens and closes on button rising edges, is limited to TIMEOUT cycles
// (overrun -> ERROR), and each completed window bumps a saturating counter.
// ERROR is left only through the per-channel clr_err.
// Ports:
//   clk, reset         clock (rising edge), async active-high reset
//   mant_btn[N_CH]     per-channel maintenance button (level, synchronous)
//   clr_err[N_CH]      per-channel error clear (level)
//   state_o[2*N_CH]    ch i at [2i+1:2i]: 00 IDLE, 01 MAINT, 10 ERROR
//   maint_cnt_o        ch i at [CNT_W*i +: CNT_W]; all-ones while in ERROR
//   done_o[N_CH]       one-cycle pulse per completed window
//   err_o[N_CH]        high while channel is in ERROR
//   any_err_o          OR of err_o

// Single channel. Instantiated once per channel by maint_ctrl_multi.
module maint_ch #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_i,
  input  logic             clr_i,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o,
  output logic             err_o
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TMR_LAST = TW'(TIMEOUT - 1);
  // All-ones is the error code, so the highest real count is all-ones minus one.
  localparam logic [CNT_W-1:0] CNT_SAT  = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ERR  = '1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_MAINT = 2'b01;
  localparam logic [1:0] ST_ERR   = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             btn_q, done_q, done_d, err_q;
  logic             rise;

  // btn_q resets low, so a button held across reset release reads as a rise.
  assign rise = btn_i & ~btn_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MAINT;
          timer_d = '0;
        end
      end
      ST_MAINT: begin
        // Timeout outranks a closing press on the same edge.
        if (timer_q == TMR_LAST) begin
          state_d = ST_ERR;
        end else if (rise) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ERR: begin
        // A press alongside the clear is ignored: ERROR always goes via IDLE.
        if (clr_i) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_i;
      done_q  <= done_d;
      err_q   <= (state_d == ST_ERR);
    end
  end

  assign state_o = state_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  // Count is held internally during ERROR; only the displayed value is masked.
  assign cnt_o   = err_q ? CNT_ERR : cnt_q;
endmodule

module maint_ctrl_multi #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       mant_btn,
  input  logic [N_CH-1:0]       clr_err,
  output logic [2*N_CH-1:0]     state_o,
  output logic [CNT_W*N_CH-1:0] maint_cnt_o,
  output logic [N_CH-1:0]       done_o,
  output logic [N_CH-1:0]       err_o,
  output logic                  any_err_o
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    maint_ch #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (mant_btn[g]),
      .clr_i   (clr_err[g]),
      .state_o (state_o[2*g +: 2]),
      .cnt_o   (maint_cnt_o[CNT_W*g +: CNT_W]),
      .done_o  (done_o[g]),
      .err_o   (err_o[g])
    );
  end

  assign any_err_o = |err_o;
endmodule

// File: tb/tb_maint_ctrl_multi.sv
module tb_maint_ctrl_multi;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    mant_btn = '0;
  logic [N-1:0]    clr_err = '0;
  logic [2*N-1:0]  state_o;
  logic [CW*N-1:0] maint_cnt_o;
  logic [N-1:0]    done_o, err_o;
  logic            any_err_o;

  int total = 0;
  int bad   = 0;

  maint_ctrl_multi #(.N_CH(N), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mant_btn(mant_btn), .clr_err(clr_err),
    .state_o(state_o), .maint_cnt_o(maint_cnt_o), .done_o(done_o),
    .err_o(err_o), .any_err_o(any_err_o)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle / 1 in window / 2 error; window age is
  // measured as elapsed cycles since the opening edge.
  int cyc;
  int m_st[N], m_start[N], m_cnt[N];
  bit m_done[N], m_prev[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_start[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_prev[i] = 0;
    end
  endtask

  task automatic model_step();
    cyc++;
    for (int i = 0; i < N; i++) begin
      bit rise;
      rise = mant_btn[i] && !m_prev[i];
      m_done[i] = 0;
      if (m_st[i] == 0) begin
        if (rise) begin m_st[i] = 1; m_start[i] = cyc; end
      end else if (m_st[i] == 1) begin
        if (cyc - m_start[i] >= TO) m_st[i] = 2;
        else if (rise) begin
          m_st[i] = 0; m_done[i] = 1;
          if (m_cnt[i] < (1 << CW) - 2) m_cnt[i]++;
        end
      end else begin
        if (clr_err[i]) m_st[i] = 0;
      end
      m_prev[i] = mant_btn[i];
    end
  endtask

  function automatic logic [2*N-1:0] exp_state();
    for (int i = 0; i < N; i++) exp_state[2*i +: 2] = 2'(m_st[i]);
  endfunction
  function automatic logic [CW*N-1:0] exp_cnt();
    for (int i = 0; i < N; i++)
      exp_cnt[CW*i +: CW] = (m_st[i] == 2) ? {CW{1'b1}} : CW'(m_cnt[i]);
  endfunction
  function automatic logic [N-1:0] exp_done();
    for (int i = 0; i < N; i++) exp_done[i] = m_done[i];
  endfunction
  function automatic logic [N-1:0] exp_err();
    for (int i = 0; i < N; i++) exp_err[i] = (m_st[i] == 2);
  endfunction

  // Advance one clock; inputs change and outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic window(input int ch);
    mant_btn[ch] = 1'b1; tick();
    mant_btn[ch] = 1'b0; tick();
    mant_btn[ch] = 1'b1; tick();
    mant_btn[ch] = 1'b0; tick();
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    total++; if (state_o !== '0) begin bad++; $display("FAIL rst_state got=%h want=0", state_o); end
    total++; if (maint_cnt_o !== '0) begin bad++; $display("FAIL rst_cnt got=%h want=0", maint_cnt_o); end
    total++; if (done_o !== '0) begin bad++; $display("FAIL rst_done got=%b want=0", done_o); end
    total++; if (err_o !== '0) begin bad++; $display("FAIL rst_err got=%b want=0", err_o); end
    total++; if (any_err_o !== 1'b0) begin bad++; $display("FAIL rst_any got=%b want=0", any_err_o); end
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  // Ch0 completes a 5-cycle window while ch1 runs into timeout.
  task automatic test_concurrent();
    int n1;
    mant_btn = 4'b0011; tick();
    total++; if (state_o[3:0] !== 4'b0101) begin bad++; $display("FAIL cc_enter got=%b want=0101", state_o[3:0]); end
    n1 = 1;
    mant_btn = '0;
    repeat (4) begin tick(); if (state_o[3:2] == 2'b01) n1++; end
    mant_btn[0] = 1'b1; tick(); if (state_o[3:2] == 2'b01) n1++;
    total++; if (state_o[1:0] !== 2'b00) begin bad++; $display("FAIL cc_ch0_idle got=%b want=00", state_o[1:0]); end
    total++; if (done_o !== 4'b0001) begin bad++; $display("FAIL cc_done got=%b want=0001", done_o); end
    total++; if (maint_cnt_o[3:0] !== 4'd1) begin bad++; $display("FAIL cc_cnt0 got=%h want=1", maint_cnt_o[3:0]); end
    mant_btn[0] = 1'b0; tick(); if (state_o[3:2] == 2'b01) n1++;
    total++; if (done_o[0] !== 1'b0) begin bad++; $display("FAIL cc_done_pulse got=%b want=0", done_o[0]); end
    for (int k = 0; k < 20 && state_o[3:2] == 2'b01; k++) begin
      tick(); if (state_o[3:2] == 2'b01) n1++;
    end
    total++; if (n1 != 10) begin bad++; $display("FAIL cc_maint_len got=%0d want=10", n1); end
    total++; if (state_o[3:2] !== 2'b10) begin bad++; $display("FAIL cc_ch1_err got=%b want=10", state_o[3:2]); end
    total++; if (err_o !== 4'b0010 || any_err_o !== 1'b1) begin bad++; $display("FAIL cc_err got=%b/%b want=0010/1", err_o, any_err_o); end
    total++; if (maint_cnt_o[7:0] !== 8'hF1) begin bad++; $display("FAIL cc_cnt01 got=%h want=f1", maint_cnt_o[7:0]); end
  endtask

  task automatic test_err_clear();
    clr_err[1] = 1'b1; tick(); clr_err[1] = 1'b0;
    total++; if (state_o[3:2] !== 2'b00 || any_err_o !== 1'b0) begin bad++; $display("FAIL ec_clear got=%b/%b want=00/0", state_o[3:2], any_err_o); end
    repeat (3) window(1);
    total++; if (maint_cnt_o[7:4] !== 4'd3) begin bad++; $display("FAIL ec_cnt3 got=%h want=3", maint_cnt_o[7:4]); end
    mant_btn[1] = 1'b1; tick(); mant_btn[1] = 1'b0;
    repeat (10) tick();
    total++; if (state_o[3:2] !== 2'b10 || maint_cnt_o[7:4] !== 4'hF) begin bad++; $display("FAIL ec_err got=%b/%h want=10/f", state_o[3:2], maint_cnt_o[7:4]); end
    clr_err[1] = 1'b1; mant_btn[1] = 1'b1; tick();
    clr_err[1] = 1'b0;
    total++; if (state_o[3:2] !== 2'b00 || maint_cnt_o[7:4] !== 4'd3) begin bad++; $display("FAIL ec_clr_rise got=%b/%h want=00/3", state_o[3:2], maint_cnt_o[7:4]); end
    tick();
    total++; if (state_o[3:2] !== 2'b00) begin bad++; $display("FAIL ec_no_maint got=%b want=00", state_o[3:2]); end
    mant_btn[1] = 1'b0; tick();
  endtask

  task automatic test_late_rise();
    int pulses = 0;
    mant_btn[2] = 1'b1; tick(); mant_btn[2] = 1'b0;
    repeat (9) begin tick(); if (done_o[2]) pulses++; end
    total++; if (state_o[5:4] !== 2'b01) begin bad++; $display("FAIL lr_still got=%b want=01", state_o[5:4]); end
    mant_btn[2] = 1'b1; tick(); if (done_o[2]) pulses++;
    total++; if (state_o[5:4] !== 2'b10 || err_o[2] !== 1'b1) begin bad++; $display("FAIL lr_err got=%b/%b want=10/1", state_o[5:4], err_o[2]); end
    mant_btn[2] = 1'b0; clr_err[2] = 1'b1; tick(); if (done_o[2]) pulses++;
    clr_err[2] = 1'b0;
    total++; if (pulses != 0) begin bad++; $display("FAIL lr_done got=%0d want=0", pulses); end
    total++; if (maint_cnt_o[11:8] !== 4'd0) begin bad++; $display("FAIL lr_cnt got=%h want=0", maint_cnt_o[11:8]); end
  endtask

  task automatic test_saturate();
    int pulses = 0;
    repeat (16) begin
      mant_btn[3] = 1'b1; tick(); if (done_o[3]) pulses++;
      mant_btn[3] = 1'b0; tick(); if (done_o[3]) pulses++;
      mant_btn[3] = 1'b1; tick(); if (done_o[3]) pulses++;
      mant_btn[3] = 1'b0; tick(); if (done_o[3]) pulses++;
    end
    total++; if (pulses != 16) begin bad++; $display("FAIL sat_pulses got=%0d want=16", pulses); end
    total++; if (maint_cnt_o[15:12] !== 4'hE) begin bad++; $display("FAIL sat_cnt got=%h want=e", maint_cnt_o[15:12]); end
  endtask

  task automatic test_reset_mid();
    mant_btn[0] = 1'b1; tick(); tick();
    total++; if (state_o[1:0] !== 2'b01) begin bad++; $display("FAIL rm_pre got=%b want=01", state_o[1:0]); end
    reset = 1'b1; model_reset(); #1;
    total++; if (state_o !== '0 || maint_cnt_o !== '0 || done_o !== '0 || err_o !== '0 || any_err_o !== 1'b0)
      begin bad++; $display("FAIL rm_zero got=%h/%h/%b/%b/%b want=all 0", state_o, maint_cnt_o, done_o, err_o, any_err_o); end
    @(negedge clk); reset = 1'b0;
    tick();
    total++; if (state_o[1:0] !== 2'b01) begin bad++; $display("FAIL rm_rise got=%b want=01", state_o[1:0]); end
    mant_btn = '0; tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) mant_btn[i] = ~mant_btn[i];
      clr_err = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      tick();
      total++;
      if (state_o !== exp_state() || maint_cnt_o !== exp_cnt() || done_o !== exp_done() ||
          err_o !== exp_err() || any_err_o !== (|exp_err())) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL rnd cyc=%0d got st=%h cnt=%h d=%b e=%b a=%b want st=%h cnt=%h d=%b e=%b a=%b",
                   cyc, state_o, maint_cnt_o, done_o, err_o, any_err_o,
                   exp_state(), exp_cnt(), exp_done(), exp_err(), |exp_err());
      end
    end
    mant_btn = '0; clr_err = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_concurrent();
    test_err_clear();
    test_late_rise();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
